// File: rtl/fetch_stage_if.sv
// Bundle of ROM-address, hazard-control and IF/ID signals around the fetch stage.
// The fetch stage uses the master view; the ROM and downstream pipeline use the slave view.
interface fetch_stage_if;
    logic [15:0] pc;
    logic [8:0]  instruction;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_target;
    logic [8:0]  if_id_instr;
    logic [15:0] if_id_pc;
    logic        if_id_valid;
    logic        halted;
    logic [15:0] fetch_count;

    modport master (
        output pc,
        output if_id_instr,
        output if_id_pc,
        output if_id_valid,
        output halted,
        output fetch_count,
        input  instruction,
        input  stall,
        input  redirect,
        input  redirect_target
    );

    modport slave (
        input  pc,
        input  if_id_instr,
        input  if_id_pc,
        input  if_id_valid,
        input  halted,
        input  fetch_count,
        output instruction,
        output stall,
        output redirect,
        output redirect_target
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads the combinational instruction ROM,
// loads the IF/ID register, and handles stall, redirect-with-flush and halt.
// Per-edge priority is reset > redirect > stall > halted > normal fetch.
module fetch_stage #(
    parameter logic [15:0] RESET_PC     = 16'd0,
    parameter logic [8:0]  BUBBLE_INSTR = 9'h1B0,
    parameter logic [4:0]  HALT_OPCODE  = 5'b11010
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_stage_if.master bus
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state_q;
    logic [15:0] pc_q;
    logic [8:0]  ifIdInstr_q;
    logic [15:0] ifIdPc_q;
    logic        ifIdValid_q;
    logic [15:0] fetchCount_q;

    logic        isHaltOp;
    logic [15:0] fetchCount_d;

    // Opcode compare on the ROM word and the saturating next value of the debug counter.
    always_comb begin
        isHaltOp     = (bus.instruction[8:4] == HALT_OPCODE);
        fetchCount_d = (fetchCount_q == 16'hFFFF) ? fetchCount_q : fetchCount_q + 16'd1;
    end

    // PC, IF/ID register, fetch counter and RUN/HALT state, all updated on one edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            ifIdInstr_q  <= BUBBLE_INSTR;
            ifIdPc_q     <= 16'd0;
            ifIdValid_q  <= 1'b0;
            fetchCount_q <= 16'd0;
        end else if (bus.redirect) begin
            // A halt fetched on the wrong path is cancelled along with the flush.
            state_q     <= RUN;
            pc_q        <= bus.redirect_target;
            ifIdInstr_q <= BUBBLE_INSTR;
            ifIdPc_q    <= 16'd0;
            ifIdValid_q <= 1'b0;
        end else if (bus.stall) begin
            state_q <= state_q;
        end else if (state_q == HALT) begin
            ifIdInstr_q <= BUBBLE_INSTR;
            ifIdPc_q    <= 16'd0;
            ifIdValid_q <= 1'b0;
        end else begin
            ifIdInstr_q  <= bus.instruction;
            ifIdPc_q     <= pc_q;
            ifIdValid_q  <= 1'b1;
            fetchCount_q <= fetchCount_d;
            if (isHaltOp) begin
                // PC stays on the halt so it is delivered exactly once as valid.
                state_q <= HALT;
            end else begin
                pc_q <= pc_q + 16'd1;
            end
        end
    end

    assign bus.pc          = pc_q;
    assign bus.if_id_instr = ifIdInstr_q;
    assign bus.if_id_pc    = ifIdPc_q;
    assign bus.if_id_valid = ifIdValid_q;
    assign bus.halted      = (state_q == HALT);
    assign bus.fetch_count = fetchCount_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// stall/redirect/reset traffic, checked through an expected-value queue.
module tb_fetch_stage;

    localparam logic [8:0] BUBBLE = 9'h1B0;

    typedef struct {
        int          pc;
        logic [8:0]  ifInstr;
        int          ifPc;
        logic        ifValid;
        logic        halted;
        int          count;
        int          wrapPc;
    } expect_t;

    logic clk;
    logic rst_n;

    fetch_stage_if mainBus ();
    fetch_stage_if wrapBus ();

    logic [8:0] rom [64];

    expect_t expQ[$];
    int checks = 0;
    int errors = 0;

    // Reference model state: the architectural view of the fetch stage.
    int         mPc;
    logic [8:0] mInstr;
    int         mIfPc;
    logic       mValid;
    logic       mHalted;
    int         mCount;
    int         mWrapPc;

    fetch_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mainBus)
    );

    fetch_stage #(.RESET_PC(16'hFFFE)) wrapDut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (wrapBus)
    );

    assign mainBus.instruction = rom[mainBus.pc[5:0]];

    assign wrapBus.instruction     = 9'h0C0;
    assign wrapBus.stall           = 1'b0;
    assign wrapBus.redirect        = 1'b0;
    assign wrapBus.redirect_target = 16'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Factorial program image: the anchor words the scenarios rely on, the rest
    // filled with opcodes 0..25 so that only address 43 holds the halt opcode.
    initial begin
        for (int a = 0; a < 64; a++) begin
            rom[a] = {5'((a * 7 + 3) % 26), 4'(a % 16)};
        end
        rom[0]  = 9'h1B0;
        rom[1]  = 9'h0C0;
        rom[10] = 9'h0C8;
        rom[15] = 9'h0A1;
        rom[27] = 9'h041;
        rom[42] = 9'h171;
        rom[43] = 9'h1A0;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle of inputs, advances the reference model by the same edge
    // and queues what the DUT must show after that edge.
    task automatic applyStimulus(input logic rstn, input logic st, input logic rd, input int tgt);
        expect_t    e;
        logic [8:0] fetched;
        @(negedge clk);
        #1;
        rst_n                   = rstn;
        mainBus.stall           = st;
        mainBus.redirect        = rd;
        mainBus.redirect_target = 16'(tgt);
        if (!rstn) begin
            mPc     = 0;
            mInstr  = BUBBLE;
            mIfPc   = 0;
            mValid  = 1'b0;
            mHalted = 1'b0;
            mCount  = 0;
            mWrapPc = 16'hFFFE;
        end else begin
            mWrapPc = (mWrapPc + 1) % 65536;
            if (rd) begin
                mPc     = tgt;
                mInstr  = BUBBLE;
                mIfPc   = 0;
                mValid  = 1'b0;
                mHalted = 1'b0;
            end else if (st) begin
                mPc = mPc;
            end else if (mHalted) begin
                mInstr = BUBBLE;
                mIfPc  = 0;
                mValid = 1'b0;
            end else begin
                fetched = rom[mPc % 64];
                mInstr  = fetched;
                mIfPc   = mPc;
                mValid  = 1'b1;
                mCount  = (mCount < 65535) ? mCount + 1 : 65535;
                if (fetched[8:4] == 5'b11010) mHalted = 1'b1;
                else                          mPc = (mPc + 1) % 65536;
            end
        end
        e.pc      = mPc;
        e.ifInstr = mInstr;
        e.ifPc    = mIfPc;
        e.ifValid = mValid;
        e.halted  = mHalted;
        e.count   = mCount;
        e.wrapPc  = mWrapPc;
        expQ.push_back(e);
    endtask

    // Free-runs until the model PC reaches the wanted address, within a cycle budget.
    task automatic runUntilPc(input int target);
        int budget;
        budget = 200;
        while (mPc != target && budget > 0) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 0);
            budget--;
        end
        checkOutput("runUntilPcBudget", mPc, target);
    endtask

    // Monitor: on every falling edge, pops the next expectation and compares it.
    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("pc",          int'(mainBus.pc),          e.pc);
                checkOutput("if_id_instr", int'(mainBus.if_id_instr), int'(e.ifInstr));
                checkOutput("if_id_pc",    int'(mainBus.if_id_pc),    e.ifPc);
                checkOutput("if_id_valid", int'(mainBus.if_id_valid), int'(e.ifValid));
                checkOutput("halted",      int'(mainBus.halted),      int'(e.halted));
                checkOutput("fetch_count", int'(mainBus.fetch_count), e.count);
                checkOutput("wrap_pc",     int'(wrapBus.pc),          e.wrapPc);
            end
        end
    end

    // Stimulus: directed scenarios first, then random traffic.
    initial begin
        int drain;
        rst_n                   = 1'b0;
        mainBus.stall           = 1'b0;
        mainBus.redirect        = 1'b0;
        mainBus.redirect_target = 16'd0;

        // Reset for three edges, then run from 0 through the halt at 43 and ten edges beyond.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 54; i++) applyStimulus(1'b1, 1'b0, 1'b0, 0);

        // Redirect at pc=5 to 27.
        applyStimulus(1'b0, 1'b0, 1'b0, 0);
        runUntilPc(5);
        applyStimulus(1'b1, 1'b0, 1'b1, 27);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 0);

        // Stall three cycles at pc=10, then stall together with redirect to 38.
        applyStimulus(1'b0, 1'b0, 1'b0, 0);
        runUntilPc(10);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 38);
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 1'b0, 0);

        // Recover from halt with a redirect to 15, then reset in the middle of a stall.
        applyStimulus(1'b1, 1'b0, 1'b1, 15);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 20);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 0);

        // Random stalls, redirects and occasional resets.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom_range(0, 99) != 0),
                          1'($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 9) == 0),
                          int'($urandom_range(0, 63)));
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 0);

        drain = 0;
        while (expQ.size() > 0 && drain < 10) begin
            @(negedge clk);
            drain++;
        end
        #1;
        checkOutput("scoreboardDrained", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
